// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 defaults and sizing helpers
// shared by the VGA raster engine files.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_COLOR_W  = 4;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  function automatic int total_len(
    int act, int fp, int sync, int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int addr_w_req(
    int h, int v
  );
    return $clog2(h * v);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-memory read port
// master issues addr/strobe, slave returns {R,G,B}.
interface vga_timing_gen_if
  import vga_timing_pkg::*;
#(
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = DEF_COLOR_W
);

  logic [ADDR_W-1:0]    pix_addr;
  logic                 pix_rd;
  logic [3*COLOR_W-1:0] pix_data;

  modport master (
    output pix_addr,
    output pix_rd,
    input  pix_data
  );

  modport slave (
    input  pix_addr,
    input  pix_rd,
    output pix_data
  );

endinterface

// File: rtl/vga_stb_delay.sv
// vga_stb_delay: enabled shift register, DEPTH stages
// of WIDTH bits; DEPTH 0 degenerates to a wire.
module vga_stb_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = ^{clk, rst_n, en};
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++)
          sr[i] <= '0;
      end else if (en) begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++)
          sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster engine with pixel strobe,
// H/V counters, linear read addresses and aligned outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 4,
  parameter int RD_LAT    = 1,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int ADDR_W    = addr_w_req(H_ACTIVE, V_ACTIVE),
  parameter int CNT_W     = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_timing_gen_if.master   mem,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               frame_start,
  output logic               line_start,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount
);

  localparam int H_TOTAL =
    total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT =
    CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT =
    CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG =
    CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END =
    CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG =
    CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END =
    CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  logic [DIV_W-1:0]  div;
  logic              stb;
  logic              act;
  logic              hs_raw;
  logic              vs_raw;
  logic              h_wrap;
  logic              v_wrap;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        dly;

  // rst_n gates the strobe so nothing pulses while held in reset
  assign stb    = rst_n && (div == DIV_LAST);
  assign h_wrap = (hcount == H_LAST);
  assign v_wrap = (vcount == V_LAST);
  assign act    = (hcount < H_ACT) && (vcount < V_ACT);
  assign hs_raw = (hcount >= HS_BEG) && (hcount < HS_END);
  assign vs_raw = (vcount >= VS_BEG) && (vcount < VS_END);

  assign mem.pix_addr = addr;
  assign mem.pix_rd   = stb && act;
  assign line_start   = stb && (hcount == '0);
  assign frame_start  = line_start && (vcount == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div <= '0;
    end else if (stb) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
      addr   <= '0;
    end else if (stb) begin
      hcount <= h_wrap ? '0 : hcount + 1'b1;
      if (h_wrap)
        vcount <= v_wrap ? '0 : vcount + 1'b1;
      if (h_wrap && v_wrap)
        addr <= '0;
      else if (act)
        addr <= addr + 1'b1;
    end
  end

  vga_stb_delay #(
    .DEPTH (RD_LAT),
    .WIDTH (3)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stb),
    .d     ({act, hs_raw, vs_raw}),
    .q     (dly)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de    <= 1'b0;
      hsync <= ~HS_ON;
      vsync <= ~VS_ON;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (stb) begin
      de    <= dly[2];
      hsync <= ~(dly[1] ^ HS_ON);
      vsync <= ~(dly[0] ^ VS_ON);
      {red, green, blue} <=
        dly[2] ? mem.pix_data : '0;
    end
  end

endmodule
